// File: rtl/pe_conv_row_sequencer.sv
// pe_conv_row_sequencer
// Runs a stride-1 1-D row convolution on a single multiplier inside a PE.
// For each output pixel it accepts an incoming partial sum, streams S
// filter/ifmap pairs out of the scratchpads through the multiplier,
// accumulates the products on top of the partial sum, and offers the
// finished sum downstream. One row produces E output pixels.
//
// Pipeline:
//   MAC cycle   : scratchpad read issued (filter tap k, ifmap pixel out_idx+k)
//   stage 2     : read data returns and is driven straight onto the multiplier
//                 operands; the multiplier registers on the falling edge, so
//                 the product is accumulated on the closing rising edge.
// DRAIN exists only to let the final stage-2 cycle complete before OUTPUT.

module pe_conv_row_sequencer #(
    parameter int PIXEL_WIDTH  = 16,
    parameter int PSUM_WIDTH   = 32,
    parameter int FILT_ADDR_W  = 4,
    parameter int IFMAP_ADDR_W = 5,
    parameter int OUT_CNT_W    = 5
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_start,
    input  logic [FILT_ADDR_W-1:0]          i_cfg_filt_len,
    input  logic [OUT_CNT_W-1:0]            i_cfg_num_out,
    output logic                            o_busy,
    output logic                            o_done,
    output logic [FILT_ADDR_W-1:0]          o_filt_addr,
    output logic [IFMAP_ADDR_W-1:0]         o_ifmap_addr,
    output logic                            o_spad_rd_en,
    input  logic signed [PIXEL_WIDTH-1:0]   i_filt_data,
    input  logic signed [PIXEL_WIDTH-1:0]   i_ifmap_data,
    output logic                            o_mul_enable,
    output logic signed [PIXEL_WIDTH-1:0]   o_mul_a,
    output logic signed [PIXEL_WIDTH-1:0]   o_mul_b,
    input  logic signed [2*PIXEL_WIDTH-1:0] i_mul_product,
    input  logic [PSUM_WIDTH-1:0]           i_psum_in,
    input  logic                            i_psum_in_valid,
    output logic                            o_psum_in_ready,
    output logic [PSUM_WIDTH-1:0]           o_psum_out,
    output logic                            o_psum_out_valid,
    input  logic                            i_psum_out_ready
);

    // FSM encoding
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_MAC    = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_OUTPUT = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [FILT_ADDR_W-1:0] FILT_ONE = FILT_ADDR_W'(1);
    localparam logic [OUT_CNT_W-1:0]   OUT_ONE  = OUT_CNT_W'(1);

    // State and datapath registers
    logic [2:0]              r_state;
    logic [FILT_ADDR_W-1:0]  r_filt_len;   // S, latched on an accepted start
    logic [OUT_CNT_W-1:0]    r_num_out;    // E, latched on an accepted start
    logic [OUT_CNT_W-1:0]    r_out_idx;    // index of the output pixel being built
    logic [FILT_ADDR_W-1:0]  r_k;          // filter tap currently being read
    logic [PSUM_WIDTH-1:0]   r_acc;        // running partial sum
    logic                    r_s2_valid;   // a read was issued last cycle

    // Combinational helpers
    logic [2:0]              w_state_next;
    logic                    w_start_acc;
    logic                    w_load_hs;
    logic                    w_out_hs;
    logic                    w_last_tap;
    logic                    w_last_out;
    logic [IFMAP_ADDR_W-1:0] w_ifmap_addr;
    logic [PSUM_WIDTH-1:0]   w_prod_ext;

    assign w_start_acc = (r_state == S_IDLE)   && i_start;
    assign w_load_hs   = (r_state == S_LOAD)   && i_psum_in_valid;
    assign w_out_hs    = (r_state == S_OUTPUT) && i_psum_out_ready;
    assign w_last_tap  = (r_k == (r_filt_len - FILT_ONE));
    assign w_last_out  = (r_out_idx == (r_num_out - OUT_ONE));

    // The ifmap window slides by one pixel per output; the address wraps
    // naturally at the scratchpad size.
    assign w_ifmap_addr = IFMAP_ADDR_W'(r_out_idx) + IFMAP_ADDR_W'(r_k);

    // Size cast of a signed operand sign-extends the product to psum width.
    assign w_prod_ext = PSUM_WIDTH'(i_mul_product);

    // Next-state decode
    // NOTE: every variable driven in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = (i_cfg_num_out == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (i_psum_in_valid) begin
                    w_state_next = (r_filt_len == '0) ? S_OUTPUT : S_MAC;
                end
            end
            S_MAC: begin
                if (w_last_tap) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_next = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (i_psum_out_ready) begin
                    w_state_next = w_last_out ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Row configuration, captured only when a start is accepted
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_filt_len <= '0;
            r_num_out  <= '0;
        end else if (w_start_acc) begin
            r_filt_len <= i_cfg_filt_len;
            r_num_out  <= i_cfg_num_out;
        end
    end

    // Output-pixel counter: cleared on start, advanced on each psum_out handshake
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_out_idx <= '0;
        end else if (w_start_acc) begin
            r_out_idx <= '0;
        end else if (w_out_hs) begin
            r_out_idx <= r_out_idx + OUT_ONE;
        end
    end

    // Tap counter: cleared when a psum is loaded, advanced once per read
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_k <= '0;
        end else if (w_load_hs) begin
            r_k <= '0;
        end else if (r_state == S_MAC) begin
            r_k <= r_k + FILT_ONE;
        end
    end

    // Stage-2 valid: marks the cycle in which read data sits on the operands
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s2_valid <= 1'b0;
        end else begin
            r_s2_valid <= (r_state == S_MAC);
        end
    end

    // Accumulator: seeded with the incoming psum, then one product per stage-2 cycle
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_acc <= '0;
        end else if (w_load_hs) begin
            r_acc <= i_psum_in;
        end else if (r_s2_valid) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    // Outputs decoded from registered state only, so they drop to zero as
    // soon as reset asserts.
    always_comb begin
        o_busy           = (r_state == S_LOAD) || (r_state == S_MAC) ||
                           (r_state == S_DRAIN) || (r_state == S_OUTPUT);
        o_done           = (r_state == S_DONE);
        o_spad_rd_en     = (r_state == S_MAC);
        o_filt_addr      = (r_state == S_MAC) ? r_k : '0;
        o_ifmap_addr     = (r_state == S_MAC) ? w_ifmap_addr : '0;
        o_mul_enable     = r_s2_valid;
        o_mul_a          = r_s2_valid ? i_ifmap_data : '0;
        o_mul_b          = r_s2_valid ? i_filt_data : '0;
        o_psum_in_ready  = (r_state == S_LOAD);
        o_psum_out_valid = (r_state == S_OUTPUT);
        o_psum_out       = (r_state == S_OUTPUT) ? r_acc : '0;
    end

endmodule
